// File: rtl/tetris_pkg.sv
// Shared playfield geometry, row/grid types and the garbage-insert state encoding.
package tetris_pkg;

  localparam int unsigned GRID_ROWS = 22;
  localparam int unsigned GRID_COLS = 10;
  localparam int unsigned CELL_W    = 3;
  localparam int unsigned MAX_GARBAGE = 4;

  typedef logic [GRID_COLS-1:0][CELL_W-1:0] row_t;
  typedef row_t [GRID_ROWS-1:0]             grid_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Garbage row count is capped so a single request cannot wipe the field.
  function automatic logic [2:0] eff_count(input logic [2:0] count);
    return (32'(count) > MAX_GARBAGE) ? 3'(MAX_GARBAGE) : count;
  endfunction

endpackage

// File: rtl/garbage_row_gen.sv
// Builds one garbage row: every cell in the given color except the hole column.
module garbage_row_gen #(
  parameter int unsigned GRID_COLS = tetris_pkg::GRID_COLS,
  parameter int unsigned CELL_W    = tetris_pkg::CELL_W
) (
  input  logic [3:0]                        hole,
  input  logic [CELL_W-1:0]                 color,
  output logic [GRID_COLS-1:0][CELL_W-1:0]  row_c
);

  always_comb begin
    row_c = '0;
    for (int unsigned c = 0; c < GRID_COLS; c++) begin
      row_c[c] = (32'(hole) == c) ? '0 : color;
    end
  end

endmodule

// File: rtl/garbage_insert.sv
// Pushes up to four garbage rows in from the bottom of the playfield, one row per cycle,
// flagging topout when a filled row is pushed off the top.
module garbage_insert
  import tetris_pkg::*;
#(
  parameter int unsigned GRID_ROWS = tetris_pkg::GRID_ROWS,
  parameter int unsigned GRID_COLS = tetris_pkg::GRID_COLS,
  parameter int unsigned CELL_W    = tetris_pkg::CELL_W
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           enable,
  input  logic [2:0]                                     count,
  input  logic [3:0]                                     hole,
  input  logic [2:0]                                     color,
  input  logic [GRID_ROWS-1:0][GRID_COLS-1:0][CELL_W-1:0] c_grid,
  output logic [GRID_ROWS-1:0][GRID_COLS-1:0][CELL_W-1:0] n_grid,
  output logic                                           done,
  output logic                                           busy,
  output logic                                           topout
);

  state_t state, state_next;

  logic [GRID_ROWS-1:0][GRID_COLS-1:0][CELL_W-1:0] work;
  logic [GRID_COLS-1:0][CELL_W-1:0]                garbage_c;
  logic [2:0]                                      rem;
  logic [3:0]                                      hole_q;
  logic [CELL_W-1:0]                               color_q;

  logic [2:0]        n_eff_c;
  logic [3:0]        hole_eff_c;
  logic [CELL_W-1:0] color_eff_c;
  logic              accept_c, shift_c, load_c;

  // Sanitise request fields before they are latched.
  always_comb begin
    n_eff_c     = eff_count(count);
    hole_eff_c  = (32'(hole) > GRID_COLS - 1) ? 4'd0 : hole;
    color_eff_c = (color == 3'd0) ? CELL_W'(3'd7) : CELL_W'(color);
  end

  garbage_row_gen #(
    .GRID_COLS (GRID_COLS),
    .CELL_W    (CELL_W)
  ) u_row_gen (
    .hole  (hole_q),
    .color (color_q),
    .row_c (garbage_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    shift_c    = 1'b0;
    load_c     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable) begin
          accept_c   = 1'b1;
          state_next = (count == 3'd0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_c = 1'b1;
        if (rem == 3'd1) state_next = ST_DONE;
      end
      ST_DONE: begin
        load_c     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Working grid, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work    <= '0;
      rem     <= 3'd0;
      hole_q  <= 4'd0;
      color_q <= '0;
      n_grid  <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      topout  <= 1'b0;
    end else begin
      done <= load_c;
      busy <= (state_next != ST_IDLE);
      if (accept_c) begin
        work    <= c_grid;
        rem     <= n_eff_c;
        hole_q  <= hole_eff_c;
        color_q <= color_eff_c;
        topout  <= 1'b0;
      end
      if (shift_c) begin
        // Row r takes row r+1; the bottom row takes the new garbage.
        work <= {garbage_c, work[GRID_ROWS-1:1]};
        rem  <= rem - 3'd1;
        if (|work[0]) topout <= 1'b1;
      end
      if (load_c) n_grid <= work;
    end
  end

endmodule

// File: doc/garbage_insert.md
GARBAGE_INSERT -- requirements
Module: garbage_insert

Interface
REQ-001 Parameters SHALL be: GRID_ROWS, default 22, playfield rows (row 0 = top, row GRID_ROWS-1 = bottom); GRID_COLS, default 10, columns; CELL_W, default 3, color bits per cell (0 = empty).
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock, the block's only clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 enable  input  1  start request, sampled only in IDLE.
REQ-006 count  input  3  garbage rows to insert.
REQ-007 hole  input  4  column left empty in every inserted row.
REQ-008 color  input  3  color of garbage cells.
REQ-009 c_grid  input  [GRID_ROWS][GRID_COLS][CELL_W]  current grid, sampled with enable.
REQ-010 n_grid  output  [GRID_ROWS][GRID_COLS][CELL_W]  registered result grid.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 topout  output  1  a non-empty cell was pushed off row 0, valid with done.

Function
REQ-014 FSM states SHALL be IDLE, SHIFT, DONE; transitions: IDLE->SHIFT on enable with N>0; IDLE->DONE on enable with N=0; SHIFT->DONE when the remaining count reaches 0; DONE->IDLE unconditionally.
REQ-015 Effective count N SHALL be min(count,4); the effective hole SHALL be 0 when hole>GRID_COLS-1; the effective color SHALL be 3'd7 when color=0.
REQ-016 On enable in IDLE, the block SHALL latch c_grid into a working register and latch N, the effective hole and the effective color; topout SHALL clear to 0 at the same time.
REQ-017 Each SHIFT cycle SHALL move working row r+1 to row r for r=0..GRID_ROWS-2, load bottom row GRID_ROWS-1 with the garbage row, and decrement the remaining count by 1.
REQ-018 The garbage row SHALL be the effective color in every column except the effective hole column, which SHALL be 0.
REQ-019 If working row 0 holds any non-zero cell in a SHIFT cycle, topout SHALL be set and SHALL stay set (sticky) until the next accepted enable; shifting SHALL still complete.
REQ-020 On entry to DONE, n_grid SHALL load the working register; done SHALL be 1 for exactly that one cycle; n_grid SHALL hold its value until the next DONE.
REQ-021 Latency SHALL be done high exactly N+1 cycles after the edge that sampled enable (N=0 gives 1 cycle, with n_grid equal to c_grid).
REQ-022 The block SHALL ignore enable while busy=1 and SHALL NOT queue it; changes to c_grid, count, hole or color after the sampling edge SHALL have no effect.
REQ-023 enable held high continuously SHALL start a new operation on the cycle after DONE (back-to-back, no extra idle cycle required beyond IDLE).

Reset
REQ-024 While rst_n=0 the block SHALL force: state IDLE, n_grid all zero, working grid zero, done 0, busy 0, topout 0, remaining count 0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation with no done pulse; the first enable after release SHALL behave as a fresh start.

Structure
REQ-026 GRID_ROWS, GRID_COLS, CELL_W, the row_t and grid_t typedefs, and the state enum SHALL live in the shared package tetris_pkg, which is also used by lineclear.
REQ-027 The combinational garbage-row builder (effective hole, effective color -> row_t) SHALL be one sub-module, garbage_row_gen; the FSM, counter and shift register SHALL be in garbage_insert.

Verification
REQ-028 Empty grid, count=2, hole=3, color=5 -> done at cycle 3; rows 20 and 21 = 5 except column 3 = 0; all other rows 0; topout=0.
REQ-029 Row 0 column 4 = 2, all else 0, count=1 -> done at cycle 2; topout=1; n_grid row 21 is garbage.
REQ-030 count=0 with arbitrary c_grid -> done at cycle 1; n_grid equals c_grid; topout=0.
REQ-031 count=7, hole=12, color=0 -> 4 rows inserted, hole column 0, garbage color 7, done at cycle 5.
REQ-032 Second enable pulse during SHIFT -> ignored, exactly one done pulse; rst_n pulsed low during SHIFT -> outputs zero, no done, next enable completes normally.
REQ-033 Row 21 = 1 in all columns, count=1 -> done at cycle 2; that row appears at row 20 and the new row 21 is garbage.
